// File: rtl/alu_writeback_stage_if.sv
// alu_writeback_stage_if
// Bundles every non-clock signal of the ALU writeback stage.
//   in_*      : ALU result beat with flags, destination and control (valid/ready)
//   flush     : drop the queued writes and the current input beat
//   wb_*      : register-file write port, head of the queue (valid/ready)
//   flags     : architectural {S,Z,C,V}; carry_flag feeds the ALU carryin
//   hz_*      : hazard lookup from decode; fwd_data returns the youngest match
// The master modport is the side that produces beats and owns the register
// file. The slave modport is the writeback stage itself.
interface alu_writeback_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic              in_overflow;
    logic              in_carryout;
    logic              in_sign;
    logic              in_we;
    logic [ADDR_W-1:0] in_rd;
    logic              in_setflags;
    logic              flush;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        flags;
    logic              carry_flag;
    logic [ADDR_W-1:0] hz_addr;
    logic              hz_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output in_valid, in_result, in_zero, in_overflow, in_carryout, in_sign,
               in_we, in_rd, in_setflags, flush, wb_ready, hz_addr,
        input  in_ready, wb_valid, wb_addr, wb_data, flags, carry_flag,
               hz_hit, fwd_data
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_overflow, in_carryout, in_sign,
               in_we, in_rd, in_setflags, flush, wb_ready, hz_addr,
        output in_ready, wb_valid, wb_addr, wb_data, flags, carry_flag,
               hz_hit, fwd_data
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
// Downstream stage of the 16-bit ALU. Accepted beats that write the register
// file go into a small FIFO that drains to the register-file write port.
// The architectural flag register is updated when a beat is accepted, not
// when it retires, so back-to-back ALU ops see the previous carry right away.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_writeback_stage_if.slave (input beat, writeback port,
//           flags, hazard/forward lookup)
module alu_writeback_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_writeback_stage_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        flags_q, flags_d;

    logic              acc;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  hz_idx;
    logic              hz_hit_c;
    logic [DATA_W-1:0] fwd_data_c;

    // in_ready depends only on the registered count, so a full queue refuses
    // input even when the head is popped in the same cycle.
    assign bus.in_ready   = (count_q < CNT_W'(DEPTH));
    assign bus.wb_valid   = (count_q != '0);
    assign bus.wb_addr    = addr_q[rd_ptr_q];
    assign bus.wb_data    = data_q[rd_ptr_q];
    assign bus.flags      = flags_q;
    assign bus.carry_flag = flags_q[1];
    assign bus.hz_hit     = hz_hit_c;
    assign bus.fwd_data   = fwd_data_c;

    // Handshake qualifiers. Flush kills both the incoming beat and any pop,
    // so the register file must also qualify its write with ~flush.
    assign acc  = bus.in_valid & bus.in_ready & ~bus.flush;
    assign push = acc & bus.in_we;
    assign pop  = bus.wb_valid & bus.wb_ready & ~bus.flush;

    // Next-state for queue storage, pointers, count and flags.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        flags_d  = flags_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                addr_d[wr_ptr_q] = bus.in_rd;
                data_d[wr_ptr_q] = bus.in_result;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        if (acc && bus.in_setflags) begin
            flags_d = {bus.in_sign, bus.in_zero, bus.in_carryout, bus.in_overflow};
        end
    end

    // Hazard search walks the queue oldest to youngest starting at rd_ptr;
    // a later match overwrites an earlier one so the youngest entry wins.
    // Only queued state is searched, never the in-flight input beat.
    always_comb begin
        hz_hit_c   = 1'b0;
        fwd_data_c = '0;
        hz_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[hz_idx] == bus.hz_addr)) begin
                hz_hit_c   = 1'b1;
                fwd_data_c = data_q[hz_idx];
            end
        end
    end

    // State registers. Reset empties the queue and clears the flags, dropping
    // any entries that were mid-drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage
// Directed self-checking bench for alu_writeback_stage. Inputs change 1ns
// after each rising edge and outputs are checked in that same settled window.
module tb_alu_writeback_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    alu_writeback_stage_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    alu_writeback_stage #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an idle input beat with all flag bits low.
    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_result   = '0;
        bus.in_zero     = 1'b0;
        bus.in_overflow = 1'b0;
        bus.in_carryout = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_we       = 1'b0;
        bus.in_rd       = '0;
        bus.in_setflags = 1'b0;
        bus.flush       = 1'b0;
    endtask

    // Drive a register-writing beat without a flag update.
    task automatic drive_beat(input logic [2:0] rd, input logic [15:0] res);
        drive_idle();
        bus.in_valid  = 1'b1;
        bus.in_we     = 1'b1;
        bus.in_rd     = rd;
        bus.in_result = res;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.wb_ready = 1'b0;
        bus.hz_addr  = 3'd0;
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_wb_valid: got %b expected 0", bus.wb_valid);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        n_checks++;
        if (bus.flags !== 4'b0000) begin
            n_fails++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", bus.flags);
        end
        n_checks++;
        if (bus.hz_hit !== 1'b0 || bus.fwd_data !== 16'h0000) begin
            n_fails++;
            $display("[TB] FAIL reset_hazard: got hit=%b fwd=%h expected hit=0 fwd=0000",
                     bus.hz_hit, bus.fwd_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_beat();
        bus.wb_ready = 1'b1;
        drive_beat(3'd3, 16'h1234);
        step();
        drive_idle();
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 3'd3 || bus.wb_data !== 16'h1234) begin
            n_fails++;
            $display("[TB] FAIL single_head: got v=%b a=%0d d=%h expected v=1 a=3 d=1234",
                     bus.wb_valid, bus.wb_addr, bus.wb_data);
        end
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL single_drained: got %b expected 0", bus.wb_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.wb_ready = 1'b0;
        drive_beat(3'd1, 16'h0001);
        step();
        drive_beat(3'd2, 16'h0002);
        step();
        drive_beat(3'd4, 16'h0003);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL bp_full_ready: got %b expected 0", bus.in_ready);
        end
        n_checks++;
        if (bus.wb_data !== 16'h0001 || bus.wb_addr !== 3'd1) begin
            n_fails++;
            $display("[TB] FAIL bp_head_stable: got a=%0d d=%h expected a=1 d=0001",
                     bus.wb_addr, bus.wb_data);
        end
        step();
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.wb_data !== 16'h0001) begin
            n_fails++;
            $display("[TB] FAIL bp_hold: got rdy=%b d=%h expected rdy=0 d=0001",
                     bus.in_ready, bus.wb_data);
        end
        // Pop while full: the third beat still waits this cycle.
        bus.wb_ready = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL bp_no_comb_ready: got %b expected 0", bus.in_ready);
        end
        step();
        n_checks++;
        if (bus.wb_data !== 16'h0002 || bus.in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL bp_second: got d=%h rdy=%b expected d=0002 rdy=1",
                     bus.wb_data, bus.in_ready);
        end
        // Simultaneous push of beat 3 and pop of beat 2.
        step();
        drive_idle();
        n_checks++;
        if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'h0003 || bus.wb_addr !== 3'd4) begin
            n_fails++;
            $display("[TB] FAIL bp_third: got v=%b a=%0d d=%h expected v=1 a=4 d=0003",
                     bus.wb_valid, bus.wb_addr, bus.wb_data);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL bp_count_one: got rdy=%b expected 1", bus.in_ready);
        end
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL bp_empty: got %b expected 0", bus.wb_valid);
        end
    endtask

    task automatic test_flags();
        bus.wb_ready = 1'b1;
        drive_idle();
        bus.in_valid    = 1'b1;
        bus.in_setflags = 1'b1;
        bus.in_carryout = 1'b1;
        bus.in_sign     = 1'b1;
        n_checks++;
        if (bus.carry_flag !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL flags_latency: got %b expected 0", bus.carry_flag);
        end
        step();
        // Second beat with setflags low and different flag inputs.
        drive_idle();
        bus.in_valid    = 1'b1;
        bus.in_zero     = 1'b1;
        bus.in_overflow = 1'b1;
        n_checks++;
        if (bus.flags !== 4'b1010 || bus.carry_flag !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL flags_set: got f=%b c=%b expected f=1010 c=1",
                     bus.flags, bus.carry_flag);
        end
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL flags_no_we: got %b expected 0", bus.wb_valid);
        end
        step();
        drive_idle();
        n_checks++;
        if (bus.flags !== 4'b1010) begin
            n_fails++;
            $display("[TB] FAIL flags_hold: got %b expected 1010", bus.flags);
        end
    endtask

    task automatic test_hazard();
        bus.wb_ready = 1'b0;
        bus.hz_addr  = 3'd5;
        drive_beat(3'd5, 16'hAAAA);
        n_checks++;
        if (bus.hz_hit !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL hz_input_not_searched: got %b expected 0", bus.hz_hit);
        end
        step();
        drive_beat(3'd5, 16'hBBBB);
        n_checks++;
        if (bus.hz_hit !== 1'b1 || bus.fwd_data !== 16'hAAAA) begin
            n_fails++;
            $display("[TB] FAIL hz_one: got hit=%b fwd=%h expected hit=1 fwd=AAAA",
                     bus.hz_hit, bus.fwd_data);
        end
        step();
        drive_idle();
        n_checks++;
        if (bus.hz_hit !== 1'b1 || bus.fwd_data !== 16'hBBBB) begin
            n_fails++;
            $display("[TB] FAIL hz_youngest: got hit=%b fwd=%h expected hit=1 fwd=BBBB",
                     bus.hz_hit, bus.fwd_data);
        end
        bus.hz_addr = 3'd2;
        #1;
        n_checks++;
        if (bus.hz_hit !== 1'b0 || bus.fwd_data !== 16'h0000) begin
            n_fails++;
            $display("[TB] FAIL hz_miss: got hit=%b fwd=%h expected hit=0 fwd=0000",
                     bus.hz_hit, bus.fwd_data);
        end
    endtask

    task automatic test_flush();
        // Queue is full from the hazard test; flags are 1010.
        drive_beat(3'd6, 16'h5555);
        bus.in_setflags = 1'b1;
        bus.in_zero     = 1'b1;
        bus.flush       = 1'b1;
        step();
        drive_idle();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL flush_full: got v=%b rdy=%b expected v=0 rdy=1",
                     bus.wb_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.flags !== 4'b1010) begin
            n_fails++;
            $display("[TB] FAIL flush_flags_kept: got %b expected 1010", bus.flags);
        end
        // Flush with room in the queue: the offered beat and its flags drop.
        drive_beat(3'd6, 16'h6666);
        bus.in_setflags = 1'b1;
        bus.flush       = 1'b1;
        step();
        drive_idle();
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.flags !== 4'b1010) begin
            n_fails++;
            $display("[TB] FAIL flush_drop_beat: got v=%b f=%b expected v=0 f=1010",
                     bus.wb_valid, bus.flags);
        end
        // Pointers restart at zero: a fresh beat appears at the head.
        drive_beat(3'd7, 16'h7777);
        step();
        drive_idle();
        n_checks++;
        if (bus.wb_addr !== 3'd7 || bus.wb_data !== 16'h7777) begin
            n_fails++;
            $display("[TB] FAIL flush_restart: got a=%0d d=%h expected a=7 d=7777",
                     bus.wb_addr, bus.wb_data);
        end
        bus.wb_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_drain();
        bus.wb_ready = 1'b0;
        drive_beat(3'd1, 16'h1111);
        step();
        drive_beat(3'd2, 16'h2222);
        step();
        drive_idle();
        bus.wb_ready = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL rst_mid_drain: got v=%b rdy=%b expected v=0 rdy=1",
                     bus.wb_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.flags !== 4'b0000) begin
            n_fails++;
            $display("[TB] FAIL rst_mid_flags: got %b expected 0000", bus.flags);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL rst_release_empty: got %b expected 0", bus.wb_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_flags();
        test_hazard();
        test_flush();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
